// File: rtl/dmap_wback_cache.sv
// Direct-mapped, write-back, write-allocate cache with a line-flush engine.
// Hits complete combinationally in IDLE. Misses evict dirty victims, then
// fill the line and replay the request as a hit.
module dmap_wback_cache #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] core_wstrb_i,
    input  logic                    core_write_i,
    input  logic                    core_read_i,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    output logic                    core_ready_o,
    input  logic                    cleanup_i,
    output logic                    cleanup_done_o,
    output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] dmem_wstrb_o,
    output logic                    dmem_write_o,
    output logic                    dmem_read_o,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
    input  logic                    dmem_ready_i,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
    localparam int unsigned BEAT_W = (WSEL_W == 0) ? 1 : WSEL_W;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned TAG_W  = ADDR_WIDTH - OFF_W - WSEL_W - IDX_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, EVICT, FILL, FLUSH_SCAN, FLUSH_WB} state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [IDX_W-1:0]    scan_idx;
    logic [DEPTH-1:0]    valid_q;
    logic [DEPTH-1:0]    dirty_q;
    logic [TAG_W-1:0]    tag_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH][LINE_WORDS];

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [BEAT_W-1:0]   req_word;
    logic                req_valid;
    logic                hit;

    // Build a line-aligned beat address from tag, index and word select.
    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0]  t,
                                                        input logic [IDX_W-1:0]  i,
                                                        input logic [BEAT_W-1:0] b);
        logic [ADDR_WIDTH-1:0] a;
        a = (ADDR_WIDTH'(t) << (OFF_W + WSEL_W + IDX_W)) | (ADDR_WIDTH'(i) << (OFF_W + WSEL_W));
        if (LINE_WORDS > 1) a = a | (ADDR_WIDTH'(b) << OFF_W);
        return a;
    endfunction

    assign req_idx   = IDX_W'(core_addr_i >> (OFF_W + WSEL_W));
    assign req_tag   = TAG_W'(core_addr_i >> (OFF_W + WSEL_W + IDX_W));
    assign req_word  = (LINE_WORDS == 1) ? '0 : BEAT_W'(core_addr_i >> OFF_W);
    assign req_valid = core_write_i | core_read_i;
    assign hit       = (state == IDLE) && req_valid && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // Core response and memory beat drive, decoded from the current state.
    always_comb begin
        core_ready_o = hit;
        core_rdata_o = hit ? data_mem[req_idx][req_word] : '0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_wstrb_o = '0;
        dmem_write_o = 1'b0;
        dmem_read_o  = 1'b0;
        case (state)
            EVICT: begin
                dmem_write_o = 1'b1;
                dmem_addr_o  = line_addr(tag_mem[req_idx], req_idx, beat);
                dmem_wdata_o = data_mem[req_idx][beat];
                dmem_wstrb_o = '1;
            end
            FILL: begin
                dmem_read_o = 1'b1;
                dmem_addr_o = line_addr(req_tag, req_idx, beat);
            end
            FLUSH_WB: begin
                dmem_write_o = 1'b1;
                dmem_addr_o  = line_addr(tag_mem[scan_idx], scan_idx, beat);
                dmem_wdata_o = data_mem[scan_idx][beat];
                dmem_wstrb_o = '1;
            end
            default: ;
        endcase
    end

    // Control FSM, line status bits, flush pulse and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            beat           <= '0;
            scan_idx       <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
            cleanup_done_o <= 1'b0;
            hit_count_o    <= '0;
            miss_count_o   <= '0;
        end else begin
            cleanup_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (hit_count_o != 32'hFFFF_FFFF) hit_count_o <= hit_count_o + 32'd1;
                        if (core_write_i) dirty_q[req_idx] <= 1'b1;
                    end else if (req_valid) begin
                        if (miss_count_o != 32'hFFFF_FFFF) miss_count_o <= miss_count_o + 32'd1;
                        beat  <= '0;
                        state <= (valid_q[req_idx] && dirty_q[req_idx]) ? EVICT : FILL;
                    end else if (cleanup_i) begin
                        scan_idx <= '0;
                        state    <= FLUSH_SCAN;
                    end
                end
                EVICT: begin
                    if (dmem_ready_i) begin
                        beat <= beat + BEAT_W'(1);
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (dmem_ready_i) begin
                        beat <= beat + BEAT_W'(1);
                        if (beat == LAST_BEAT) begin
                            beat             <= '0;
                            valid_q[req_idx] <= 1'b1;
                            dirty_q[req_idx] <= 1'b0;
                            state            <= IDLE;
                        end
                    end
                end
                FLUSH_SCAN: begin
                    if (valid_q[scan_idx] && dirty_q[scan_idx]) begin
                        beat  <= '0;
                        state <= FLUSH_WB;
                    end else if (scan_idx == LAST_IDX) begin
                        cleanup_done_o <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                FLUSH_WB: begin
                    if (dmem_ready_i) begin
                        beat <= beat + BEAT_W'(1);
                        if (beat == LAST_BEAT) begin
                            beat              <= '0;
                            dirty_q[scan_idx] <= 1'b0;
                            if (scan_idx == LAST_IDX) begin
                                cleanup_done_o <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                scan_idx <= scan_idx + IDX_W'(1);
                                state    <= FLUSH_SCAN;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays: strobed write hits and fill beats; no reset needed.
    always_ff @(posedge clk) begin
        if (hit && core_write_i) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (core_wstrb_i[b]) data_mem[req_idx][req_word][8*b +: 8] <= core_wdata_i[8*b +: 8];
            end
        end
        if (state == FILL && dmem_ready_i) begin
            data_mem[req_idx][beat] <= dmem_rdata_i;
            if (beat == LAST_BEAT) tag_mem[req_idx] <= req_tag;
        end
    end

endmodule

// File: doc/dmap_wback_cache.md
DMAP_WBACK_CACHE -- requirements
Module: dmap_wback_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 32, number of lines; a power of 2.
REQ-004 SHALL have parameter LINE_WORDS, default 4, words per line; a power of 2, at least 1.
REQ-005 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have core ports core_addr_i in ADDR_WIDTH; core_wdata_i in DATA_WIDTH; core_wstrb_i in DATA_WIDTH/8; core_write_i in 1; core_read_i in 1; core_rdata_o out DATA_WIDTH; core_ready_o out 1.
REQ-008 SHALL have flush ports cleanup_i in 1 (flush request) and cleanup_done_o out 1 (flush complete pulse).
REQ-009 SHALL have memory ports dmem_addr_o out ADDR_WIDTH; dmem_wdata_o out DATA_WIDTH; dmem_wstrb_o out DATA_WIDTH/8; dmem_write_o out 1; dmem_read_o out 1; dmem_rdata_i in DATA_WIDTH; dmem_ready_i in 1.
REQ-010 SHALL have counter ports hit_count_o out 32 and miss_count_o out 32.

Function
REQ-011 SHALL split each address into fields, from LSB up: byte offset log2(DATA_WIDTH/8); word select log2(LINE_WORDS); index log2(DEPTH); tag = remaining upper bits.
REQ-012 SHALL keep per-line valid, dirty, tag and LINE_WORDS data words; direct-mapped, write-back, write-allocate.
REQ-013 SHALL use FSM states IDLE, EVICT, FILL, FLUSH_SCAN, FLUSH_WB.
REQ-014 Core request rule: the core holds addr/data/strobe stable until core_ready_o; write takes priority when core_write_i and core_read_i are both high.
REQ-015 Hit in IDLE (valid and tag match): core_ready_o=1 in the same cycle (combinational), no dmem traffic, hit_count_o increments.
REQ-016 Read hit: core_rdata_o = selected word in that cycle; core_rdata_o=0 whenever core_ready_o=0.
REQ-017 Write hit: only strobed bytes are updated at the clock edge; the line is marked dirty.
REQ-018 Miss in IDLE: miss_count_o increments once; next state is EVICT if the victim is valid and dirty, otherwise FILL; core_ready_o=0.
REQ-019 EVICT: issues LINE_WORDS sequential writes, word 0 first, at {victim tag, index, word, 0}, with all strobes set; then enters FILL.
REQ-020 FILL: issues LINE_WORDS sequential reads, word 0 first; each dmem_rdata_i is stored on dmem_ready_i; after the last beat, tag is set, valid=1, dirty=0, and the FSM returns to IDLE.
REQ-021 After FILL, the request replays in IDLE as a hit and is counted as a hit. Miss latency = beats + 1 cycle.
REQ-022 dmem handshake: read/write, addr, wdata and wstrb are held constant until dmem_ready_i=1; one beat completes per ready cycle. The next beat may start in the cycle after ready. Read and write are never high together.
REQ-023 Flush start: cleanup_i is sampled only in IDLE with no core request; a core request blocks the flush.
REQ-024 FLUSH_SCAN walks indices 0..DEPTH-1, one index per cycle when clean. A valid dirty line enters FLUSH_WB, which writes all LINE_WORDS words per REQ-019, clears dirty (valid stays), and resumes at the next index.
REQ-025 After index DEPTH-1: cleanup_done_o=1 for exactly one cycle, then return to IDLE. A flush always runs to completion. cleanup_i held high starts a new flush after the pulse.
REQ-026 Counters SHALL saturate at 0xFFFF_FFFF.
REQ-027 All beat and index counters SHALL wrap using exact log2 widths.

Reset
REQ-028 While rst_n=0, the following SHALL hold and take effect asynchronously: all valid and dirty bits 0; FSM IDLE; counters 0; core_ready_o=0; core_rdata_o=0; cleanup_done_o=0; all dmem outputs 0.
REQ-029 Reset during EVICT, FILL or a flush SHALL abort the transaction immediately; the data array need not be reset.

Verification
Defaults apply: index = addr[8:4], word = addr[3:2].
REQ-030 After reset, read 0x104 -> reads at 0x100, 0x104, 0x108, 0x10C; then core_ready_o with the word returned for 0x104; miss_count=1, hit_count=1.
REQ-031 Then write 0x104, wdata 0xAABBCCDD, wstrb 0b0010 -> ready the same cycle, no dmem traffic; a read of 0x104 returns the old word with byte1 = 0xCC.
REQ-032 Then read 0x304 (same index, new tag) -> writes at 0x100..0x10C with wstrb 0xF, the second write holding 0xCC in byte1; then reads at 0x300..0x30C; miss_count=2.
REQ-033 Dirty lines at indices 1 and 5, cleanup_i pulse -> exactly 8 writes (0x010..0x01C, 0x050..0x05C), one cleanup_done_o pulse; a second flush gives 0 writes and 1 pulse.
REQ-034 dmem_ready_i delayed 3 cycles per beat -> dmem outputs stable across the wait, beat order unchanged; rst_n low mid-FILL -> all outputs 0, a following read of 0x104 misses.
